// File: rtl/mem_xfer_ctrl.sv
// mem_xfer_ctrl
// Sequencer for the memory A -> add/sub datapath -> memory B transfer path.
// Walks memory A addresses 0..Len-1, strobes each word into the datapath and,
// for every word after the first, writes the datapath result for the pair
// (word i-1, word i) to memory B address i-1.
//
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   Start, Len     transfer request and word count (legal 2..DEPTH), sampled in IDLE
//   Abort          cancels a transfer in RD/LAT/WR
//   AddrA, RdEnA   memory A read address / enable (synchronous read)
//   DataValid      datapath latches the current memory A word this cycle
//   AddrB, WrEnB   memory B write address / enable
//   Busy           transfer in progress
//   Done           one-cycle pulse on normal completion
//   Aborted        one-cycle pulse after an abort
//   Err            one-cycle pulse after a Start with an illegal Len
//
// Every output is decoded from registers only; no input reaches an output
// combinationally.
module mem_xfer_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Start,
  input  logic [ADDR_W:0]   Len,
  input  logic              Abort,
  output logic [ADDR_W-1:0] AddrA,
  output logic              RdEnA,
  output logic              DataValid,
  output logic [ADDR_W-1:0] AddrB,
  output logic              WrEnB,
  output logic              Busy,
  output logic              Done,
  output logic              Aborted,
  output logic              Err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_LAT  = 3'd2,
    S_WR   = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]   LEN_MIN = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0]   LEN_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   IDX_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;     // one bit wider than the address so Len=DEPTH never wraps
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic              err_q, err_d;
  logic              aborted_q, aborted_d;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      addr_a_q  <= addr_a_d;
      addr_b_q  <= addr_b_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
    end
  end

  // Next-state logic. Addresses are loaded on entry to RD/WR so they are
  // registered outputs and simply hold their value while IDLE.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    addr_a_d  = addr_a_q;
    addr_b_d  = addr_b_q;
    err_d     = 1'b0;
    aborted_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Abort is ignored here, so Start wins when both are high.
        if (Start) begin
          if ((Len >= LEN_MIN) && (Len <= LEN_MAX)) begin
            len_d    = Len;
            idx_d    = '0;
            addr_a_d = '0;
            state_d  = S_RD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_RD: begin
        if (Abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else begin
          state_d = S_LAT;
        end
      end

      S_LAT: begin
        if (Abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (idx_q == '0) begin
          // First word only primes the datapath; nothing to write yet.
          idx_d    = IDX_ONE;
          addr_a_d = ADR_ONE;
          state_d  = S_RD;
        end else begin
          addr_b_d = idx_q[ADDR_W-1:0] - ADR_ONE;
          state_d  = S_WR;
        end
      end

      S_WR: begin
        if (Abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (idx_q == (len_q - IDX_ONE)) begin
          state_d = S_FIN;
        end else begin
          idx_d    = idx_q + IDX_ONE;
          addr_a_d = idx_d[ADDR_W-1:0];
          state_d  = S_RD;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    RdEnA     = (state_q == S_RD);
    DataValid = (state_q == S_LAT);
    WrEnB     = (state_q == S_WR);
    Done      = (state_q == S_FIN);
    Busy      = (state_q != S_IDLE);
    AddrA     = addr_a_q;
    AddrB     = addr_b_q;
    Err       = err_q;
    Aborted   = aborted_q;
  end

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
module tb_mem_xfer_ctrl;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              Start = 1'b0;
  logic [ADDR_W:0]   Len   = '0;
  logic              Abort = 1'b0;
  logic [ADDR_W-1:0] AddrA, AddrB;
  logic              RdEnA, DataValid, WrEnB, Busy, Done, Aborted, Err;

  mem_xfer_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .Start(Start), .Len(Len), .Abort(Abort),
    .AddrA(AddrA), .RdEnA(RdEnA), .DataValid(DataValid),
    .AddrB(AddrB), .WrEnB(WrEnB), .Busy(Busy), .Done(Done),
    .Aborted(Aborted), .Err(Err)
  );

  always #5 clock = ~clock;

  // Memory A, datapath (sum of previous and current word) and memory B models.
  logic [7:0] mem_a [DEPTH];
  logic [7:0] mem_b [DEPTH];
  logic [7:0] rdata, dp_prev, dp_cur;

  always @(posedge clock) begin
    if (RdEnA) rdata <= mem_a[AddrA];
    if (DataValid) begin
      dp_prev <= dp_cur;
      dp_cur  <= rdata;
    end
    if (WrEnB) mem_b[AddrB] <= dp_prev + dp_cur;
  end

  // Event monitor: counts strobes and checks address ordering per transfer.
  int busy_cnt = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0, abt_cnt = 0, err_cnt = 0;
  int seq_err = 0;
  logic [ADDR_W-1:0] rd_exp = '0, wr_exp = '0;

  always @(negedge clock) begin
    if (Busy) busy_cnt <= busy_cnt + 1;
    if (Done) done_cnt <= done_cnt + 1;
    if (Aborted) abt_cnt <= abt_cnt + 1;
    if (Err) err_cnt <= err_cnt + 1;
    if (RdEnA) begin
      rd_cnt <= rd_cnt + 1;
      if (AddrA !== rd_exp) seq_err <= seq_err + 1;
      rd_exp <= rd_exp + 1'b1;
    end
    if (WrEnB) begin
      wr_cnt <= wr_cnt + 1;
      if (AddrB !== wr_exp) seq_err <= seq_err + 1;
      wr_exp <= wr_exp + 1'b1;
    end
    if (!Busy) begin
      rd_exp <= '0;
      wr_exp <= '0;
    end
  end

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      step(1);
      if (!Busy) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, ok}, 32'd1);
    step(2);
  endtask

  task automatic start_xfer(input int n);
    Start = 1'b1;
    Len   = (ADDR_W+1)'(n);
    step(1);
    Start = 1'b0;
  endtask

  int b_busy, b_rd, b_wr, b_done, b_abt, b_err, b_seq;

  task automatic snap();
    b_busy = busy_cnt; b_rd = rd_cnt; b_wr = wr_cnt;
    b_done = done_cnt; b_abt = abt_cnt; b_err = err_cnt; b_seq = seq_err;
  endtask

  initial begin
    logic ok;
    for (int k = 0; k < DEPTH; k++) mem_a[k] = 8'((k * 37 + 5) ^ (k << 4));

    // Reset state
    step(2);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_outs", {25'd0, RdEnA, DataValid, WrEnB, Done, Aborted, Err, 1'b0}, 32'd0);
    check("rst_addr", {24'd0, AddrA, AddrB}, 32'd0);
    reset = 1'b0;
    step(2);

    // Len=4 transfer
    snap();
    start_xfer(4);
    wait_idle("len4_timeout");
    check("len4_busy", busy_cnt - b_busy, 32'd12);
    check("len4_rd", rd_cnt - b_rd, 32'd4);
    check("len4_wr", wr_cnt - b_wr, 32'd3);
    check("len4_done", done_cnt - b_done, 32'd1);
    check("len4_seq", seq_err - b_seq, 32'd0);
    check("len4_b0", {24'd0, mem_b[0]}, {24'd0, 8'(mem_a[0] + mem_a[1])});
    check("len4_b1", {24'd0, mem_b[1]}, {24'd0, 8'(mem_a[1] + mem_a[2])});
    check("len4_b2", {24'd0, mem_b[2]}, {24'd0, 8'(mem_a[2] + mem_a[3])});
    check("len4_addr_hold", {24'd0, AddrA, AddrB}, {24'd0, 4'd3, 4'd2});

    // Len=DEPTH transfer, no wrap
    snap();
    start_xfer(DEPTH);
    wait_idle("len16_timeout");
    check("len16_busy", busy_cnt - b_busy, 32'd48);
    check("len16_rd", rd_cnt - b_rd, 32'd16);
    check("len16_wr", wr_cnt - b_wr, 32'd15);
    check("len16_done", done_cnt - b_done, 32'd1);
    check("len16_seq", seq_err - b_seq, 32'd0);
    check("len16_last_addr", {24'd0, AddrA, AddrB}, {24'd0, 4'd15, 4'd14});
    check("len16_b14", {24'd0, mem_b[14]}, {24'd0, 8'(mem_a[14] + mem_a[15])});

    // Illegal lengths
    snap();
    start_xfer(1);
    check("len1_err", {31'd0, Err}, 32'd1);
    check("len1_busy", {31'd0, Busy}, 32'd0);
    step(1);
    check("len1_err_pulse", {31'd0, Err}, 32'd0);
    start_xfer(17);
    check("len17_err", {31'd0, Err}, 32'd1);
    step(3);
    check("illegal_err_cnt", err_cnt - b_err, 32'd2);
    check("illegal_no_activity", (busy_cnt - b_busy) + (rd_cnt - b_rd) + (wr_cnt - b_wr), 32'd0);

    // Abort during the second WR of a Len=6 transfer
    snap();
    start_xfer(6);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (WrEnB && AddrB == 4'd1) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    check("abort_reach_wr1", {31'd0, ok}, 32'd1);
    Abort = 1'b1;
    step(1);
    Abort = 1'b0;
    check("abort_pulse", {31'd0, Aborted}, 32'd1);
    check("abort_idle", {31'd0, Busy}, 32'd0);
    check("abort_wr", wr_cnt - b_wr, 32'd2);
    check("abort_b1", {24'd0, mem_b[1]}, {24'd0, 8'(mem_a[1] + mem_a[2])});
    Start = 1'b1;
    Len   = 5'd2;
    step(1);
    Start = 1'b0;
    check("abort_restart", {30'd0, Busy, RdEnA}, 32'd3);
    wait_idle("abort_restart_timeout");
    check("abort_aborted_cnt", abt_cnt - b_abt, 32'd1);
    check("abort_done_cnt", done_cnt - b_done, 32'd1);
    check("abort_seq", seq_err - b_seq, 32'd0);

    // Asynchronous reset mid-LAT of a Len=8 transfer
    start_xfer(8);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (DataValid && AddrA == 4'd2) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    check("rst_reach_lat", {31'd0, ok}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_rst_outs", {24'd0, RdEnA, DataValid, WrEnB, Busy, Done, Aborted, Err, 1'b0}, 32'd0);
    check("async_rst_addr", {24'd0, AddrA, AddrB}, 32'd0);
    step(1);
    snap();
    reset = 1'b0;
    step(6);
    check("post_rst_wr", wr_cnt - b_wr, 32'd0);
    check("post_rst_busy", busy_cnt - b_busy, 32'd0);

    // Start re-pulsed while busy with a different Len
    snap();
    start_xfer(5);
    Start = 1'b1;
    Len   = 5'd3;
    step(3);
    Start = 1'b0;
    wait_idle("busy_start_timeout");
    check("busy_start_rd", rd_cnt - b_rd, 32'd5);
    check("busy_start_wr", wr_cnt - b_wr, 32'd4);
    check("busy_start_busy", busy_cnt - b_busy, 32'd15);
    check("busy_start_done", done_cnt - b_done, 32'd1);

    // Abort in FIN and in IDLE is ignored
    snap();
    start_xfer(2);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (Done) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    check("fin_reach", {31'd0, ok}, 32'd1);
    Abort = 1'b1;
    step(3);
    Abort = 1'b0;
    step(1);
    check("fin_abort_done", done_cnt - b_done, 32'd1);
    check("fin_idle_abort_ignored", abt_cnt - b_abt, 32'd0);

    // Start and Abort together in IDLE: Start wins
    snap();
    Abort = 1'b1;
    start_xfer(3);
    Abort = 1'b0;
    check("start_abort_busy", {31'd0, Busy}, 32'd1);
    wait_idle("start_abort_timeout");
    check("start_abort_done", done_cnt - b_done, 32'd1);
    check("start_abort_wr", wr_cnt - b_wr, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_xfer_ctrl.md
Name: mem_xfer_ctrl

Overview:
- Sequencer for the memory-transfer path: memory A read port → add/sub datapath → memory B write port.
- Walks addresses 0..Len-1 of memory A and strobes each word into the add/sub datapath.
- After each word beyond the first, writes the datapath result (a function of word i-1 and word i) to memory B at address i-1.
- Provides a Start/Busy/Done handshake to the system, plus Abort and a length error flag.

Parameters:
- ADDR_W, 4, address width of memories A and B.
- DEPTH, 16, words per memory; must equal 2**ADDR_W.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- Start  input  1  request a transfer; sampled only in IDLE.
- Len  input  ADDR_W+1  word count; sampled together with Start; legal range 2..DEPTH.
- Abort  input  1  cancels a transfer in progress.
- AddrA  output  ADDR_W  memory A read address.
- RdEnA  output  1  memory A read enable; synchronous read, data valid the next cycle.
- DataValid  output  1  strobe: datapath latches the current memory A word this cycle.
- AddrB  output  ADDR_W  memory B write address.
- WrEnB  output  1  memory B write enable; memory B writes the datapath result DataInB.
- Busy  output  1  transfer in progress.
- Done  output  1  one-cycle pulse on normal completion.
- Aborted  output  1  one-cycle pulse when Abort terminates a transfer.
- Err  output  1  one-cycle pulse when Start is rejected because Len is illegal.

Behaviour:
- Moore machine: every output is a registered-state decode. No input reaches an output combinationally.
- Reset, asynchronous, any time including mid-transfer:
  - State returns to IDLE; index and length registers clear to 0.
  - All outputs are 0 at once. No further reads or writes are issued.
- States: IDLE, RD, LAT, WR, FIN.
- IDLE:
  - Start=1 with 2<=Len<=DEPTH: latch Len, set index i=0, go to RD.
  - Start=1 with Len<2 or Len>DEPTH: Err=1 for the next cycle, stay in IDLE.
  - Start=0: stay in IDLE.
- RD: RdEnA=1, AddrA=i, Busy=1. Always go to LAT.
- LAT: DataValid=1, Busy=1.
  - i==0: set i=1, go to RD (no write yet).
  - i>0: go to WR.
- WR: WrEnB=1, AddrB=i-1, Busy=1.
  - i==Len-1: go to FIN.
  - Otherwise: i=i+1, go to RD.
- FIN: Done=1, Busy=1 for exactly one cycle, then go to IDLE.
- Timing:
  - Busy is high for 2+3*(Len-1)+1 cycles.
  - Memory B receives exactly Len-1 writes, at addresses 0..Len-2 in ascending order.
- Index register is ADDR_W+1 bits wide, so Len=DEPTH needs no wrap. AddrA and AddrB carry the low ADDR_W bits only.
- Start while Busy=1 is ignored. Len changes while Busy=1 are ignored.
- Abort=1 sampled in RD, LAT or WR:
  - Next state is IDLE; Aborted=1 for that one cycle.
  - Done is never asserted for this transfer.
  - Strobes already asserted in the current cycle still complete, so a WR-cycle write lands.
- Abort in FIN: Done still pulses; Abort is ignored. Abort in IDLE: ignored.
- Start and Abort together in IDLE: Start wins.
- In IDLE: Busy, RdEnA, DataValid and WrEnB are 0. AddrA and AddrB hold their last values; they are 0 after reset.

Test Plan:
- Reset released, Start=1, Len=4 → RdEnA at AddrA 0,1,2,3; WrEnB at AddrB 0,1,2; Busy high 12 cycles; Done pulses once on cycle 12; memory B[0..2] match the datapath's add/sub results for pairs (A0,A1), (A1,A2), (A2,A3).
- Len=DEPTH=16 → last read at AddrA=15, last write at AddrB=14; 15 writes total; no address wrap; Done once.
- Start with Len=1, then with Len=17 → Err pulses once each time; Busy, RdEnA and WrEnB stay 0.
- Abort asserted during the second WR of a Len=6 transfer → writes to B[0] and B[1] only; Aborted pulses once; Done never asserts; a new Start is accepted the following cycle.
- reset pulsed mid-LAT in a Len=8 transfer → all outputs 0 immediately (asynchronously, before the next clock edge); after release, IDLE with no stray WrEnB.
- Start re-pulsed while Busy=1 with a different Len → ignored; the original transfer length is preserved.
